adder_pipe: RTL and testbench
=============================

ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (>=1).
REQ-002 SHALL have parameter CHUNK, default 4, bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK, with STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand set this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand, unsigned or two's complement.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry-in; used only when sub=0.
REQ-010 SHALL have port sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1).
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-013 SHALL have port sum  output  WIDTH+1  result; sum[WIDTH] = final carry-out.
REQ-014 SHALL have port ovf  output  1  signed two's-complement overflow of the WIDTH-bit result.

Function
REQ-015 SHALL accept an operand set when in_valid && in_ready are both high at a rising edge; a, b, cin and sub are sampled only then.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational, global stall).
REQ-017 SHALL advance every pipeline stage, including bubbles, only when in_ready is high; when in_ready is low, all stage registers and outputs hold.
REQ-018 SHALL compute CHUNK bits per stage: stage k adds slice k of a and b' (b' = sub ? ~b : b) plus the carry registered by stage k-1; stage 0 uses carry-in = sub ? 1 : cin.
REQ-019 SHALL carry not-yet-added upper operand slices forward in skew registers and completed lower sum slices forward in deskew registers, so all slices of one transaction emerge together.
REQ-020 SHALL have latency exactly STAGES cycles: an operand set accepted at edge N produces out_valid=1 with its result after edge N+STAGES when no stall occurs; each stall cycle adds one cycle.
REQ-021 SHALL sustain throughput of one transaction per cycle while out_ready stays high.
REQ-022 SHALL hold sum, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL compute sum[WIDTH] as the carry out of the MSB; for sub=1, sum[WIDTH]=1 means no borrow (a >= b unsigned).
REQ-024 SHALL compute ovf = carry into MSB XOR carry out of MSB, tracked through the last stage.
REQ-025 SHALL deassert out_valid after a handshake (out_valid && out_ready) when no new transaction reaches the output stage on the same edge.
REQ-026 SHALL, when a transaction arrives at the output on the same edge that the previous result is consumed, present the new result with out_valid remaining 1 and drop or duplicate no transaction.
REQ-027 SHALL ignore a, b, cin and sub whenever in_valid=0 or in_ready=0.
REQ-028 SHALL degenerate to a single registered stage when CHUNK = WIDTH (STAGES=1, latency 1).

Reset
REQ-029 SHALL, while rst_n=0, force out_valid=0, sum=0, ovf=0 and all stage valid bits to 0, independent of clk.
REQ-030 SHALL drive in_ready=1 during and after reset, since out_valid=0.
REQ-031 SHALL discard all in-flight transactions on reset assertion mid-operation; no result for them appears after rst_n returns high.
REQ-032 SHALL not require reset on datapath-only registers whose contents are qualified by a stage valid bit, except sum and ovf, which are reset.

Verification (WIDTH=8, CHUNK=4, STAGES=2)
REQ-033 SHALL pass: a=4, b=5, cin=0, sub=0, out_ready=1 -> out_valid exactly 2 cycles after acceptance, sum=9, ovf=0.
REQ-034 SHALL pass: a=255, b=1, cin=0 -> sum=256 (sum[8]=1), ovf=0; then a=127, b=1 -> sum=128, ovf=1; then a=15, b=3, cin=1 -> sum=19, with the chunk carry crossing stage 0 to stage 1.
REQ-035 SHALL pass: sub=1, a=3, b=5 -> sum[7:0]=254, sum[8]=0, ovf=0; sub=1, a=128, b=1 -> sum[7:0]=127, sum[8]=1, ovf=1; cin=1 ignored in both cases.
REQ-036 SHALL pass back-to-back: 4 transactions issued on consecutive cycles with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
REQ-037 SHALL pass backpressure: 3 transactions issued, out_ready=0 for 5 cycles, then 1 -> in_ready=0 while the output is stalled, the first result is held unchanged, and all 3 results emerge in order with none lost.
REQ-038 SHALL pass reset mid-flight: 2 transactions accepted, rst_n pulsed low for 1 cycle before either completes -> out_valid=0 immediately, no result appears afterwards, and a new a=1, b=1 yields sum=2 after 2 cycles.

Source files
------------

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined chunked adder/subtractor with valid/ready flow control
//
// Purpose:
//   Adds (or subtracts) two WIDTH-bit operands CHUNK bits per pipeline stage.
//   Operands are captured in an input register on the accepting edge; stage k
//   then adds slice k using the carry registered by stage k-1. Upper operand
//   slices not yet added ride along in skew registers and finished lower sum
//   slices ride along in deskew registers, so a whole result leaves the last
//   stage at once. Latency is STAGES cycles after acceptance. A single global
//   stall (in_ready low) freezes every stage, bubbles included.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1)
//   CHUNK  bits added per stage; WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present
//   in_ready   block can accept an operand set this cycle
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in, used only for addition
//   sub        0: a+b+cin   1: a-b
//   out_valid  result present
//   out_ready  consumer accepts the result this cycle
//   sum        WIDTH+1 bit result, sum[WIDTH] is the final carry-out
//   ovf        signed overflow of the WIDTH-bit result

module adder_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             out_valid_q;
  logic [WIDTH:0]   sum_q;
  logic             ovf_q;

  // Results produced by the last stage's combinational adder.
  logic             last_v;
  logic [WIDTH:0]   res_d;
  logic             ovf_d;

  // One enable for the whole pipe: nothing moves while the output is blocked.
  logic adv;
  assign in_ready = !out_valid_q || out_ready;
  assign adv      = in_ready;

  // ---------------------------------------------------------------------------
  // Input register. Subtraction is folded in here (invert b, force carry-in 1)
  // so every stage downstream is a plain adder.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff_d;
  logic             c0_d;
  logic             in_v_q;
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;
  logic             in_c_q;

  assign b_eff_d = sub ? ~b : b;
  assign c0_d    = sub ? 1'b1 : cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_v_q <= 1'b0;
    end else if (adv) begin
      in_v_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      in_a_q <= a;
      in_b_q <= b_eff_d;
      in_c_q <= c0_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Adder stages. Stage k reads its sources from the register bank behind it
  // (input register for k=0) and writes the bank in front of it. Register
  // widths shrink/grow per stage: RW operand bits still to add, PW sum bits done.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [CHUNK-1:0] x_a;
    logic [CHUNK-1:0] x_b;
    logic             x_c;
    logic             x_v;
    logic [CHUNK:0]   add;

    if (k == 0) begin : g_src
      assign x_a = in_a_q[CHUNK-1:0];
      assign x_b = in_b_q[CHUNK-1:0];
      assign x_c = in_c_q;
      assign x_v = in_v_q;
    end else begin : g_src
      assign x_a = g_st[k-1].g_fwd.ra_q[CHUNK-1:0];
      assign x_b = g_st[k-1].g_fwd.rb_q[CHUNK-1:0];
      assign x_c = g_st[k-1].g_fwd.c_q;
      assign x_v = g_st[k-1].g_fwd.v_q;
    end

    assign add = {1'b0, x_a} + {1'b0, x_b} + {{CHUNK{1'b0}}, x_c};

    if (k < STAGES - 1) begin : g_fwd
      localparam int RW = WIDTH - (k + 1) * CHUNK;
      localparam int PW = (k + 1) * CHUNK;

      logic          v_q;
      logic          c_q;
      logic [RW-1:0] ra_q;
      logic [RW-1:0] rb_q;
      logic [PW-1:0] ps_q;
      logic [RW-1:0] ra_d;
      logic [RW-1:0] rb_d;
      logic [PW-1:0] ps_d;

      if (k == 0) begin : g_up
        assign ra_d = in_a_q[WIDTH-1:CHUNK];
        assign rb_d = in_b_q[WIDTH-1:CHUNK];
        assign ps_d = add[CHUNK-1:0];
      end else begin : g_up
        // Drop the slice just consumed; append the new sum slice on top.
        assign ra_d = g_st[k-1].g_fwd.ra_q[RW+CHUNK-1:CHUNK];
        assign rb_d = g_st[k-1].g_fwd.rb_q[RW+CHUNK-1:CHUNK];
        assign ps_d = {add[CHUNK-1:0], g_st[k-1].g_fwd.ps_q};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q <= x_v;
        end
      end

      // Datapath contents are only meaningful alongside v_q, so no reset.
      always_ff @(posedge clk) begin
        if (adv) begin
          c_q  <= add[CHUNK];
          ra_q <= ra_d;
          rb_q <= rb_d;
          ps_q <= ps_d;
        end
      end
    end else begin : g_out
      // Carry into the MSB recovered from the MSB sum bit and its two inputs.
      logic cmsb;
      assign cmsb   = add[CHUNK-1] ^ x_a[CHUNK-1] ^ x_b[CHUNK-1];
      assign last_v = x_v;
      assign ovf_d  = cmsb ^ add[CHUNK];

      if (k == 0) begin : g_join
        assign res_d = add;
      end else begin : g_join
        assign res_d = {add, g_st[k-1].g_fwd.ps_q};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. sum/ovf only load on a real transaction so a bubble never
  // disturbs the last presented result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= last_v;
      if (last_v) begin
        sum_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard testbench for adder_pipe (WIDTH=8, CHUNK=4)

module tb_adder_pipe;

  localparam int STAGES = 2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
  logic       ovf;

  adder_pipe #(.WIDTH(8), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] s;
    logic       o;
    bit         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one operand set from a negedge; push the expected result only on
  // the edge that actually accepts it. Returns at the negedge after acceptance.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                      input logic tsub, input logic [8:0] es, input logic eo,
                      input bit lat);
    bit   got;
    exp_t e;
    got      = 0;
    a        = ta;
    b        = tb;
    cin      = tcin;
    sub      = tsub;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (in_ready) begin
        e.s = es;
        e.o = eo;
        e.lat = lat;
        e.acc = cyc + 1;
        q.push_back(e);
        got = 1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = 8'h5A;
    b        = 8'hC3;
    cin      = 1'b1;
    sub      = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: compare every handshaken result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sum", int'(sum), int'(e.s));
          chk("ovf", int'(ovf), int'(e.o));
          if (e.lat) chk("latency", cyc - e.acc, STAGES);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sum", int'(sum), 0);
    chk("rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with latency check
    send(8'd4, 8'd5, 1'b0, 1'b0, 9'd9, 1'b0, 1);
    idle();
    drain();

    // Carry-out, signed overflow, chunk carry crossing, subtraction with cin ignored
    send(8'd255, 8'd1, 1'b0, 1'b0, 9'd256, 1'b0, 0);
    send(8'd127, 8'd1, 1'b0, 1'b0, 9'd128, 1'b1, 0);
    send(8'd15,  8'd3, 1'b1, 1'b0, 9'd19,  1'b0, 0);
    send(8'd3,   8'd5, 1'b1, 1'b1, 9'h0FE, 1'b0, 0);
    send(8'd128, 8'd1, 1'b1, 1'b1, 9'h17F, 1'b1, 0);
    idle();
    drain();

    // Back-to-back: each result exactly STAGES after its own acceptance
    send(8'd10,  8'd20,  1'b0, 1'b0, 9'd30,  1'b0, 1);
    send(8'd200, 8'd100, 1'b0, 1'b0, 9'h12C, 1'b0, 1);
    send(8'd100, 8'd100, 1'b0, 1'b0, 9'd200, 1'b1, 1);
    send(8'd0,   8'd0,   1'b1, 1'b0, 9'd1,   1'b0, 1);
    idle();
    drain();

    // Backpressure: output blocked for 5 cycles with junk offered at the input
    out_ready = 1'b0;
    send(8'd1,   8'd2,   1'b0, 1'b0, 9'd3,   1'b0, 0);
    send(8'd50,  8'd20,  1'b0, 1'b1, 9'h11E, 1'b0, 0);
    send(8'h80,  8'h80,  1'b0, 1'b0, 9'h100, 1'b1, 0);
    idle();
    in_valid = 1'b1;
    a        = 8'hAA;
    b        = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_sum_held", int'(sum), 3);
      @(negedge clk);
    end
    idle();
    out_ready = 1'b1;
    drain();

    // Reset with two transactions in flight
    send(8'd7, 8'd8, 1'b0, 1'b0, 9'd15, 1'b0, 0);
    send(8'd9, 8'd9, 1'b0, 1'b0, 9'd18, 1'b0, 0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_sum", int'(sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    repeat (6) @(negedge clk);
    send(8'd1, 8'd1, 1'b0, 1'b0, 9'd2, 1'b0, 1);
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
